// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : mips_pkg                                           |
// | Description : Shared widths, register index constants and word/ |
// |               index typedefs for the MIPS datapath (register     |
// |               file, ALU, decode).                                |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  // Architectural register indices with fixed roles.
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_reg_read_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mips_reg_read_port                                 |
// | Description : One combinational read port of the register file.  |
// |               Forces index 0 to read as zero and, when BYPASS is |
// |               set, forwards an in-flight write to the reader.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
// | Ports                                                            |
// |   rd_addr     : register index being read                        |
// |   stored_data : value currently held at rd_addr in the array     |
// |   wr_valid    : a write is presented this cycle (reset-gated)    |
// |   wr_addr     : index of the presented write                     |
// |   wr_data     : data of the presented write                      |
// |   rd_data     : resolved read value                              |
// +------------------------------------------------------------------+
module mips_reg_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic rd_is_zero;
  logic bypass_hit;

  assign rd_is_zero = (rd_addr == '0);

  // A write to index 0 is dropped, so it can never be forwarded either.
  assign bypass_hit = BYPASS && wr_valid && (wr_addr != '0) && (wr_addr == rd_addr);

  always_comb begin
    rd_data = stored_data;
    if (rd_is_zero) begin
      rd_data = '0;
    end else if (bypass_hit) begin
      rd_data = wr_data;
    end
  end

endmodule : mips_reg_read_port
`default_nettype wire

// File: rtl/mips_reg_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mips_reg_file                                      |
// | Description : 32-entry MIPS general-purpose register file. Two   |
// |               zero-latency read ports (rs/rt -> ALU in1/in2),    |
// |               one write port from writeback. $zero reads as 0,   |
// |               $sp resets to SP_RESET.                            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
// | Ports                                                            |
// |   clk       : rising-edge clock                                  |
// |   rst       : asynchronous active-high reset                     |
// |   rd_addr_a : read port A index (rs)                             |
// |   rd_addr_b : read port B index (rt)                             |
// |   rd_data_a : port A data, feeds ALU in1                         |
// |   rd_data_b : port B data, feeds ALU in2                         |
// |   wr_en     : write enable from writeback                        |
// |   wr_addr   : write index                                        |
// |   wr_data   : write data                                         |
// |   wr_ack    : one-cycle pulse after an accepted write            |
// +------------------------------------------------------------------+
module mips_reg_file #(
  parameter int                 DATA_W   = mips_pkg::DATA_W,
  parameter int                 ADDR_W   = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  SP_RESET = 'h0000_3FFC,
  parameter bit                 BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack
);

  import mips_pkg::*;

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_ack_q;
  logic              wr_ack_d;

  logic              wr_accept;
  logic              wr_valid_rd;

  assign wr_accept = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  // While reset is held the array shows its reset contents, so a write
  // presented during reset must not be forwarded to the readers.
  assign wr_valid_rd = wr_en && !rst;

  // Written as an if so that an unknown wr_en leaves state untouched
  // in simulation rather than propagating X into the array.
  always_comb begin
    regs_d   = regs_q;
    wr_ack_d = 1'b0;
    if (wr_accept) begin
      regs_d[wr_addr] = wr_data;
      wr_ack_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i[ADDR_W-1:0]] <= (i == REG_SP) ? SP_RESET : '0;
      end
      wr_ack_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign wr_ack = wr_ack_q;

  mips_reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_a (
    .rd_addr     (rd_addr_a),
    .stored_data (regs_q[rd_addr_a]),
    .wr_valid    (wr_valid_rd),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data_a)
  );

  mips_reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_b (
    .rd_addr     (rd_addr_b),
    .stored_data (regs_q[rd_addr_b]),
    .wr_valid    (wr_valid_rd),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data_b)
  );

endmodule : mips_reg_file
`default_nettype wire

// File: tb/tb_mips_reg_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_mips_reg_file                                   |
// | Description : Self-checking bench for mips_reg_file. Drives one  |
// |               forwarding and one non-forwarding instance with    |
// |               identical stimulus and compares both against an    |
// |               array-based model plus literal expectations.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_mips_reg_file;

  localparam int          DW   = 32;
  localparam int          AW   = 5;
  localparam logic [31:0] SP_R = 32'h0000_3FFC;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;

  logic [DW-1:0] byp_a, byp_b, nb_a, nb_b;
  logic          byp_ack, nb_ack;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  mips_reg_file #(.DATA_W(DW), .ADDR_W(AW), .SP_RESET(SP_R), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(byp_a), .rd_data_b(byp_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(byp_ack)
  );

  mips_reg_file #(.DATA_W(DW), .ADDR_W(AW), .SP_RESET(SP_R), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_a), .rd_data_b(nb_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(nb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of architectural register contents.
  logic [DW-1:0] mdl [32];
  logic          mdl_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] <= (i == 29) ? SP_R : 32'h0;
      mdl_ack <= 1'b0;
    end else if (wr_en === 1'b1 && wr_addr != 0) begin
      mdl[wr_addr] <= wr_data;
      mdl_ack      <= 1'b1;
    end else begin
      mdl_ack <= 1'b0;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit fwd);
    if (a == 0) return '0;
    if (fwd && !rst && wr_en === 1'b1 && wr_addr != 0 && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_on && !$isunknown(wr_en)) begin
      check("cmp_byp_a", byp_a, exp_rd(rd_addr_a, 1'b1));
      check("cmp_byp_b", byp_b, exp_rd(rd_addr_b, 1'b1));
      check("cmp_nb_a",  nb_a,  exp_rd(rd_addr_a, 1'b0));
      check("cmp_nb_b",  nb_b,  exp_rd(rd_addr_b, 1'b0));
      check("cmp_byp_ack", {31'h0, byp_ack}, {31'h0, mdl_ack});
      check("cmp_nb_ack",  {31'h0, nb_ack},  {31'h0, mdl_ack});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = en; wr_addr = a; wr_data = d;
  endtask

  // Directed writes that exercise the compare process across many indices.
  typedef struct { logic [AW-1:0] wa; logic [DW-1:0] wd; logic [AW-1:0] ra; logic [AW-1:0] rb; } vec_t;
  vec_t vecs [8];

  initial begin
    vecs[0] = '{5'd1,  32'hA5A5_0001, 5'd1,  5'd31};
    vecs[1] = '{5'd31, 32'h8000_0000, 5'd31, 5'd1};
    vecs[2] = '{5'd17, 32'hFFFF_FFFF, 5'd16, 5'd17};
    vecs[3] = '{5'd16, 32'h0000_0010, 5'd17, 5'd16};
    vecs[4] = '{5'd0,  32'h1111_1111, 5'd0,  5'd0};
    vecs[5] = '{5'd29, 32'h0000_1000, 5'd29, 5'd8};
    vecs[6] = '{5'd8,  32'h0BAD_F00D, 5'd9,  5'd8};
    vecs[7] = '{5'd2,  32'h0000_0002, 5'd2,  5'd2};

    rst = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    set_wr(1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    // Reset contents visible combinationally while rst is held.
    rd_addr_a = 5'd0; rd_addr_b = 5'd29; #1;
    check("rst_r0", byp_a, 32'h0);
    check("rst_sp", byp_b, 32'h0000_3FFC);
    rd_addr_a = 5'd5; #1;
    check("rst_r5", byp_a, 32'h0);
    check("rst_ack", {31'h0, byp_ack}, 32'h0);
    tick; tick;
    rst = 1'b0;
    cmp_on = 1'b1;

    // Basic write/read with an ack pulse per accepted write.
    set_wr(1'b1, 5'd8, 32'd5); tick;
    check("ack_w8", {31'h0, byp_ack}, 32'h1);
    set_wr(1'b1, 5'd9, 32'd7); tick;
    check("ack_w9", {31'h0, byp_ack}, 32'h1);
    set_wr(1'b0, 5'd0, 32'd0); tick;
    check("ack_drop", {31'h0, byp_ack}, 32'h0);
    rd_addr_a = 5'd8; rd_addr_b = 5'd9; #1;
    check("rd_r8", byp_a, 32'd5);
    check("rd_r9", byp_b, 32'd7);
    check("rd_nb_r9", nb_b, 32'd7);

    // $zero is never written and never forwarded.
    rd_addr_a = 5'd0;
    set_wr(1'b1, 5'd0, 32'hDEAD_BEEF); #1;
    check("zero_pre", byp_a, 32'h0);
    tick;
    check("zero_ack", {31'h0, byp_ack}, 32'h0);
    check("zero_post", byp_a, 32'h0);
    set_wr(1'b0, 5'd0, 32'h0);

    // Forwarding: $10 holds 1, write 0x1234 while both ports read $10.
    set_wr(1'b1, 5'd10, 32'd1); tick;
    set_wr(1'b0, 5'd0, 32'd0);
    rd_addr_a = 5'd10; rd_addr_b = 5'd10; #1;
    check("byp_init", byp_a, 32'd1);
    set_wr(1'b1, 5'd10, 32'h1234); #1;
    check("byp_a_pre", byp_a, 32'h1234);
    check("byp_b_pre", byp_b, 32'h1234);
    check("nb_a_pre",  nb_a,  32'd1);
    check("nb_b_pre",  nb_b,  32'd1);
    tick;
    set_wr(1'b0, 5'd0, 32'd0); #1;
    check("byp_a_post", byp_a, 32'h1234);
    check("nb_b_post",  nb_b,  32'h1234);

    // Asynchronous reset in the middle of a write to $29.
    rd_addr_a = 5'd29; rd_addr_b = 5'd8;
    set_wr(1'b1, 5'd29, 32'hFFFF); #1;
    check("sp_fwd", byp_a, 32'hFFFF);
    #2 rst = 1'b1; #1;
    check("arst_sp_byp", byp_a, 32'h0000_3FFC);
    check("arst_sp_nb",  nb_a,  32'h0000_3FFC);
    check("arst_r8",     byp_b, 32'h0);
    check("arst_ack",    {31'h0, byp_ack}, 32'h0);
    tick;
    set_wr(1'b0, 5'd0, 32'd0);
    rst = 1'b0; #1;
    check("arst_sp_after", byp_a, 32'h0000_3FFC);
    tick;
    check("arst_sp_edge", byp_a, 32'h0000_3FFC);
    check("arst_ack_after", {31'h0, byp_ack}, 32'h0);

    // Unknown write enable must leave state alone.
    set_wr(1'b1, 5'd12, 32'h0000_00AA); tick;
    set_wr(1'bx, 5'd12, 32'h0000_0055); tick;
    set_wr(1'b0, 5'd0, 32'd0);
    rd_addr_a = 5'd12; #1;
    check("x_state", byp_a, 32'h0000_00AA);
    check("x_ack", {31'h0, byp_ack}, 32'h0);

    // Table-driven writes; the compare process checks every cycle.
    foreach (vecs[i]) begin
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      set_wr(1'b1, vecs[i].wa, vecs[i].wd);
      tick;
    end
    set_wr(1'b0, 5'd0, 32'd0);
    rd_addr_a = 5'd17; rd_addr_b = 5'd31; #1;
    check("tbl_r17", byp_a, 32'hFFFF_FFFF);
    check("tbl_r31", byp_b, 32'h8000_0000);
    rd_addr_a = 5'd29; rd_addr_b = 5'd8; #1;
    check("tbl_r29", byp_a, 32'h0000_1000);
    check("tbl_r8",  nb_b,  32'h0BAD_F00D);
    tick; tick;

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mips_reg_file
`default_nettype wire
